// File: rtl/mux_pkg.sv
// Shared constants and the lane-select type for the 4-to-1 lane multiplexer.
// Everything that needs to agree on the lane count or select width imports this.
package mux_pkg;

   localparam int NUM_LANES = 4;
   localparam int SEL_W     = 2;

   typedef logic [SEL_W-1:0] sel_t;

endpackage : mux_pkg

// File: rtl/mux_sel_dec.sv
// Select decoder: turns a binary lane select into a one-hot lane enable vector.
module mux_sel_dec
   import mux_pkg::*;
(
   input  sel_t                 sel_i,
   output logic [NUM_LANES-1:0] onehot_o
);

   // Every select code is spelled out so the enable vector is never X for a
   // known select; the default arm only exists to keep the block latch-free.
   always_comb begin
      onehot_o = '0;
      case (sel_i)
         2'd0:    onehot_o = 4'b0001;
         2'd1:    onehot_o = 4'b0010;
         2'd2:    onehot_o = 4'b0100;
         2'd3:    onehot_o = 4'b1000;
         default: onehot_o = '0;
      endcase
   end

endmodule : mux_sel_dec

// File: rtl/mux_4to1.sv
// Four-lane multiplexer with a zero-latency combinational output and a
// one-clock registered copy qualified by valid_i.
module mux_4to1
   import mux_pkg::*;
#(
   parameter int LANE_W = 1
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NUM_LANES*LANE_W-1:0] data_i,
   input  sel_t                        sel_i,
   input  logic                        valid_i,
   output logic [LANE_W-1:0]           out_o,
   output logic [NUM_LANES-1:0]        sel_onehot_o,
   output logic [LANE_W-1:0]           out_q_o,
   output logic                        valid_o
);

   logic [NUM_LANES-1:0] laneEnable;
   logic [LANE_W-1:0]    selectedLane;

   mux_sel_dec selDecoder (
      .sel_i    (sel_i),
      .onehot_o (laneEnable)
   );

   // Lane selection is an AND-OR tree: each lane is masked by its one-hot
   // enable and the masked lanes are ORed together, so only one can survive.
   always_comb begin
      selectedLane = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         selectedLane = selectedLane | (data_i[k*LANE_W +: LANE_W] & {LANE_W{laneEnable[k]}});
      end
   end

   assign out_o        = selectedLane;
   assign sel_onehot_o = laneEnable;

   // Registered copy: capture the selected lane when valid_i is high, otherwise
   // keep the last result but drop valid_o. Reset wins over valid_i.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q_o <= '0;
         valid_o <= 1'b0;
      end else if (valid_i) begin
         out_q_o <= selectedLane;
         valid_o <= 1'b1;
      end else begin
         valid_o <= 1'b0;
      end
   end

endmodule : mux_4to1

// File: tb/tb_mux_4to1.sv
// Directed self-checking bench for mux_4to1, exercising a 1-bit and an 8-bit
// lane instance side by side from shared clock, reset, select and valid.
module tb_mux_4to1;

   logic        clock;
   logic        reset;
   logic [1:0]  sel;
   logic        valid;
   logic [3:0]  data1;
   logic [31:0] data8;

   logic        out1;
   logic [3:0]  onehot1;
   logic        outQ1;
   logic        validQ1;
   logic [7:0]  out8;
   logic [3:0]  onehot8;
   logic [7:0]  outQ8;
   logic        validQ8;

   int assertCount;
   int failCount;

   mux_4to1 #(.LANE_W(1)) dutNarrow (
      .clk_i        (clock),
      .rst_i        (reset),
      .data_i       (data1),
      .sel_i        (sel),
      .valid_i      (valid),
      .out_o        (out1),
      .sel_onehot_o (onehot1),
      .out_q_o      (outQ1),
      .valid_o      (validQ1)
   );

   mux_4to1 #(.LANE_W(8)) dutWide (
      .clk_i        (clock),
      .rst_i        (reset),
      .data_i       (data8),
      .sel_i        (sel),
      .valid_i      (valid),
      .out_o        (out8),
      .sel_onehot_o (onehot8),
      .out_q_o      (outQ8),
      .valid_o      (validQ8)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Drive a new input vector just after a falling edge, away from the active edge.
   task automatic applyStimulus(input logic r, input logic v, input logic [3:0] d1,
                                input logic [31:0] d8, input logic [1:0] s);
      @(negedge clock);
      reset = r;
      valid = v;
      data1 = d1;
      data8 = d8;
      sel   = s;
   endtask

   // Step past the next rising edge so registered outputs have settled.
   task automatic nextEdge();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      logic [3:0] pattern;
      assertCount = 0;
      failCount   = 0;
      reset = 1'b1;
      valid = 1'b0;
      data1 = 4'b0000;
      data8 = 32'h0;
      sel   = 2'd0;

      // Combinational decode, data 1010
      data1 = 4'b1010;
      sel = 2'd0; #10;
      checkOutput("comb_1010_s0", 32'(out1), 32'd0);
      checkOutput("onehot_s0", 32'(onehot1), 32'h1);
      sel = 2'd1; #10;
      checkOutput("comb_1010_s1", 32'(out1), 32'd1);
      checkOutput("onehot_s1", 32'(onehot1), 32'h2);
      sel = 2'd2; #10;
      checkOutput("comb_1010_s2", 32'(out1), 32'd0);
      checkOutput("onehot_s2", 32'(onehot1), 32'h4);
      sel = 2'd3; #10;
      checkOutput("comb_1010_s3", 32'(out1), 32'd1);
      checkOutput("onehot_s3", 32'(onehot1), 32'h8);

      // Data 0101 sweep
      data1 = 4'b0101;
      sel = 2'd0; #1; checkOutput("comb_0101_s0", 32'(out1), 32'd1);
      sel = 2'd1; #1; checkOutput("comb_0101_s1", 32'(out1), 32'd0);
      sel = 2'd2; #1; checkOutput("comb_0101_s2", 32'(out1), 32'd1);
      sel = 2'd3; #1; checkOutput("comb_0101_s3", 32'(out1), 32'd0);

      // Exhaustive 16 x 4 sweep of the narrow instance
      for (int d = 0; d < 16; d++) begin
         for (int s = 0; s < 4; s++) begin
            pattern = 4'(d);
            data1 = pattern;
            sel = 2'(s);
            #1;
            checkOutput("comb_sweep", 32'(out1), 32'(pattern[s]));
            checkOutput("onehot_sweep", 32'(onehot1), 32'(4'b0001 << s));
         end
      end

      // Reset held for two clocks
      applyStimulus(1'b1, 1'b0, 4'b0000, 32'h0, 2'd0);
      nextEdge();
      nextEdge();
      checkOutput("reset_outq1", 32'(outQ1), 32'd0);
      checkOutput("reset_valid1", 32'(validQ1), 32'd0);
      checkOutput("reset_outq8", 32'(outQ8), 32'd0);

      // Single capture, then hold with valid dropped
      applyStimulus(1'b0, 1'b1, 4'b1000, 32'h11223344, 2'd3);
      #1;
      checkOutput("precapture_valid", 32'(validQ1), 32'd0);
      nextEdge();
      checkOutput("capture_outq", 32'(outQ1), 32'd1);
      checkOutput("capture_valid", 32'(validQ1), 32'd1);
      checkOutput("capture_outq8", 32'(outQ8), 32'h11);
      applyStimulus(1'b0, 1'b0, 4'b1000, 32'h11223344, 2'd3);
      nextEdge();
      checkOutput("hold_outq", 32'(outQ1), 32'd1);
      checkOutput("hold_valid", 32'(validQ1), 32'd0);

      // Select change between edges: out_o moves now, out_q_o waits
      applyStimulus(1'b0, 1'b0, 4'b1000, 32'h11223344, 2'd0);
      #1;
      checkOutput("midcycle_out", 32'(out1), 32'd0);
      checkOutput("midcycle_outq", 32'(outQ1), 32'd1);
      nextEdge();
      checkOutput("novalid_outq", 32'(outQ1), 32'd1);

      // Back-to-back captures on data 1010
      applyStimulus(1'b0, 1'b1, 4'b1010, 32'h0, 2'd0);
      nextEdge();
      checkOutput("b2b_outq_s0", 32'(outQ1), 32'd0);
      checkOutput("b2b_valid_s0", 32'(validQ1), 32'd1);
      applyStimulus(1'b0, 1'b1, 4'b1010, 32'h0, 2'd1);
      nextEdge();
      checkOutput("b2b_outq_s1", 32'(outQ1), 32'd1);
      checkOutput("b2b_valid_s1", 32'(validQ1), 32'd1);
      applyStimulus(1'b0, 1'b1, 4'b1010, 32'h0, 2'd2);
      nextEdge();
      checkOutput("b2b_outq_s2", 32'(outQ1), 32'd0);
      checkOutput("b2b_valid_s2", 32'(validQ1), 32'd1);
      applyStimulus(1'b0, 1'b1, 4'b1010, 32'h0, 2'd3);
      nextEdge();
      checkOutput("b2b_outq_s3", 32'(outQ1), 32'd1);
      checkOutput("b2b_valid_s3", 32'(validQ1), 32'd1);

      // Reset overriding a valid capture
      applyStimulus(1'b1, 1'b1, 4'b1111, 32'hFFFFFFFF, 2'd3);
      nextEdge();
      checkOutput("rst_override_outq", 32'(outQ1), 32'd0);
      checkOutput("rst_override_valid", 32'(validQ1), 32'd0);
      checkOutput("rst_override_out", 32'(out1), 32'd1);
      checkOutput("rst_override_out8", 32'(out8), 32'hFF);
      checkOutput("rst_override_outq8", 32'(outQ8), 32'd0);

      // First capture after reset release
      applyStimulus(1'b0, 1'b1, 4'b0100, 32'h0, 2'd2);
      #1;
      checkOutput("release_before_edge", 32'(validQ1), 32'd0);
      nextEdge();
      checkOutput("release_outq", 32'(outQ1), 32'd1);
      checkOutput("release_valid", 32'(validQ1), 32'd1);

      // Wide lanes
      applyStimulus(1'b0, 1'b1, 4'b0000, 32'hDDCCBBAA, 2'd2);
      #1;
      checkOutput("wide_out", 32'(out8), 32'hCC);
      checkOutput("wide_onehot", 32'(onehot8), 32'h4);
      nextEdge();
      checkOutput("wide_outq", 32'(outQ8), 32'hCC);
      checkOutput("wide_valid", 32'(validQ8), 32'd1);
      applyStimulus(1'b0, 1'b0, 4'b0000, 32'hDDCCBBAA, 2'd0);
      #1;
      checkOutput("wide_out_s0", 32'(out8), 32'hAA);
      applyStimulus(1'b0, 1'b0, 4'b0000, 32'hDDCCBBAA, 2'd3);
      #1;
      checkOutput("wide_out_s3", 32'(out8), 32'hDD);
      nextEdge();
      checkOutput("wide_hold_outq", 32'(outQ8), 32'hCC);
      checkOutput("wide_hold_valid", 32'(validQ8), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule : tb_mux_4to1

// File: doc/mux_4to1.md
MUX_4TO1 -- requirements
Module: mux_4to1

Interface
REQ-001 Parameter: LANE_W, default 1, bit width of each of the four data lanes.
REQ-002 Port: clk_i  input  1  single clock; all sequential logic on rising edge.
REQ-003 Port: rst_i  input  1  reset, synchronous, active-high.
REQ-004 Port: data_i  input  4*LANE_W  four packed lanes; lane k = data_i[k*LANE_W +: LANE_W].
REQ-005 Port: sel_i  input  2  lane select, unsigned, 0..3.
REQ-006 Port: valid_i  input  1  qualifies data_i/sel_i for the registered path.
REQ-007 Port: out_o  output  LANE_W  combinational selected lane.
REQ-008 Port: sel_onehot_o  output  4  combinational one-hot decode of sel_i.
REQ-009 Port: out_q_o  output  LANE_W  registered selected lane.
REQ-010 Port: valid_o  output  1  out_q_o holds a valid captured result.

Function
REQ-011 out_o SHALL equal lane sel_i of data_i: sel 00->lane0, 01->lane1, 10->lane2, 11->lane3.
REQ-012 out_o SHALL be purely combinational, zero-cycle latency, independent of clk_i and rst_i.
REQ-013 sel_onehot_o SHALL have exactly bit sel_i set: 00->0001, 01->0010, 10->0100, 11->1000.
REQ-014 On a rising edge with rst_i low and valid_i high, out_q_o SHALL load the combinational out_o value and valid_o SHALL be set to 1.
REQ-015 On a rising edge with rst_i low and valid_i low, out_q_o SHALL hold its value and valid_o SHALL be cleared to 0.
REQ-016 Registered path latency SHALL be exactly one clock from valid_i sampled high to out_q_o/valid_o.
REQ-017 Back-to-back valid_i cycles SHALL produce back-to-back results, one per clock, no bubbles.
REQ-018 Changes to data_i or sel_i between edges SHALL affect out_o immediately and out_q_o only at the next qualifying edge.
REQ-019 With known inputs, no output SHALL ever be X or Z; all four sel_i codes SHALL be decoded explicitly (no default-to-X).

Reset
REQ-020 While rst_i is high at a rising edge, out_q_o SHALL become all-zero and valid_o SHALL become 0, overriding valid_i.
REQ-021 Reset asserted mid-stream SHALL discard the in-flight capture; first valid result after release appears one clock after valid_i is sampled high with rst_i low.
REQ-022 out_o and sel_onehot_o SHALL NOT depend on rst_i.

Structure
REQ-023 A shared package mux_pkg SHALL hold constants NUM_LANES = 4 and SEL_W = 2 and the select typedef sel_t (logic [SEL_W-1:0]).
REQ-024 One sub-module mux_sel_dec (sel_t in, 4-bit one-hot out) SHALL implement the decode; the lane selection SHALL be an AND-OR of lanes gated by the one-hot.
REQ-025 The registered path SHALL be a single always_ff block; the combinational path SHALL use always_comb/continuous assignment only.

Verification
REQ-026 LANE_W=1, data_i=1010, sel_i=00/01/10/11, 10 time units each -> out_o = 0/1/0/1, sel_onehot_o = 0001/0010/0100/1000.
REQ-027 data_i=0101, sweep sel_i 00..11 -> out_o = 1/0/1/0; exhaustive sweep of all 16 data_i x 4 sel_i values -> out_o == data_i[sel_i] every case.
REQ-028 rst_i high 2 clocks, then valid_i=1, data_i=1000, sel_i=11 -> one clock later out_q_o=1, valid_o=1; next clock with valid_i=0 -> out_q_o=1 held, valid_o=0.
REQ-029 Four consecutive valid cycles with sel_i=00,01,10,11 on data_i=1010 -> out_q_o = 0,1,0,1 on the four following clocks, valid_o high throughout.
REQ-030 rst_i asserted while valid_i=1 with data_i=1111 -> out_q_o=0, valid_o=0 at that edge; out_o still 1.
REQ-031 LANE_W=8, data_i=0xDDCCBBAA, sel_i=10 -> out_o=0xCC; registered one clock later out_q_o=0xCC.
